// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with forwarding operand select and load-use detect
// Ports: clk/rst_n (sync active-low); id_* decoded fields from ID; stall/flush pipeline control;
//   exm_*/mwb_* writeback sources for forwarding; alu_a/alu_b/alu_op to the ALU;
//   ex_valid/ex_rd/ex_reg_write/ex_rt_data registered EX state; load_use to the ID stall controller.
// Build option: define EX_FWD_EN to enable forwarding muxes and stall-time operand refresh.
module ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src_imm,
  input  logic [3:0]    id_alu_op,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          stall,
  input  logic          flush,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic [DW-1:0] ex_rt_data,
  output logic          load_use
);
  logic          valid_r, src_imm_r, we_r, mr_r;
  logic [RW-1:0] rs_r, rt_r, rd_r;
  logic [DW-1:0] rs_data_r, rt_data_r, imm_r;
  logic [3:0]    op_r;
  logic [DW-1:0] rs_val, rt_val;
`ifdef EX_FWD_EN
  // EX/MEM is the younger producer, so it wins; register 0 never forwards
  always_comb begin
    rs_val = (exm_reg_write && exm_rd != '0 && exm_rd == rs_r) ? exm_data :
             (mwb_reg_write && mwb_rd != '0 && mwb_rd == rs_r) ? mwb_data : rs_data_r;
    rt_val = (exm_reg_write && exm_rd != '0 && exm_rd == rt_r) ? exm_data :
             (mwb_reg_write && mwb_rd != '0 && mwb_rd == rt_r) ? mwb_data : rt_data_r;
  end
`else
  logic unused;
  assign unused = ^{exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data, rs_r, rt_r};
  assign rs_val = rs_data_r;
  assign rt_val = rt_data_r;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      src_imm_r <= 1'b0;
      we_r      <= 1'b0;
      mr_r      <= 1'b0;
      rs_r      <= '0;
      rt_r      <= '0;
      rd_r      <= '0;
      rs_data_r <= '0;
      rt_data_r <= '0;
      imm_r     <= '0;
      op_r      <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      mr_r    <= 1'b0;
      op_r    <= '0;
    end else if (stall) begin
`ifdef EX_FWD_EN
      // capture a producer that may retire while we are held
      rs_data_r <= rs_val;
      rt_data_r <= rt_val;
`endif
    end else begin
      valid_r   <= id_valid;
      src_imm_r <= id_alu_src_imm;
      we_r      <= id_reg_write;
      mr_r      <= id_mem_read;
      rs_r      <= id_rs;
      rt_r      <= id_rt;
      rd_r      <= id_rd;
      rs_data_r <= id_rs_data;
      rt_data_r <= id_rt_data;
      imm_r     <= id_imm;
      op_r      <= id_alu_op;
    end
  end
  assign alu_a        = rs_val;
  assign alu_b        = src_imm_r ? imm_r : rt_val;
  assign ex_rt_data   = rt_val;
  assign alu_op       = op_r;
  assign ex_valid     = valid_r;
  assign ex_rd        = rd_r;
  assign ex_reg_write = we_r & valid_r;
  assign load_use     = valid_r & mr_r & (rd_r != '0) & (rd_r == id_rs | rd_r == id_rt) & id_valid;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed vectors with a queue scoreboard for ex_operand_stage
module tb_ex_operand_stage;
`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, id_valid, id_alu_src_imm, id_reg_write, id_mem_read, stall, flush;
  logic exm_reg_write, mwb_reg_write;
  logic [4:0] id_rs, id_rt, id_rd, exm_rd, mwb_rd, ex_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exm_data, mwb_data;
  logic [3:0] id_alu_op, alu_op;
  logic [31:0] alu_a, alu_b, ex_rt_data;
  logic ex_valid, ex_reg_write, load_use;
  typedef struct {
    string nm;
    bit v, we, lu, mops;
    logic [3:0] op;
    logic [31:0] a, b, rtd;
    logic [4:0] rd;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int n_vec = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src_imm(id_alu_src_imm), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_rt_data(ex_rt_data), .load_use(load_use)
  );
  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      me = q.pop_front();
      n_vec++;
      chk(me.nm, "ex_valid", 32'(ex_valid), 32'(me.v));
      chk(me.nm, "ex_reg_write", 32'(ex_reg_write), 32'(me.we));
      chk(me.nm, "load_use", 32'(load_use), 32'(me.lu));
      chk(me.nm, "alu_op", 32'(alu_op), 32'(me.op));
      if (me.mops) begin
        chk(me.nm, "alu_a", alu_a, me.a);
        chk(me.nm, "alu_b", alu_b, me.b);
        chk(me.nm, "ex_rt_data", ex_rt_data, me.rtd);
        chk(me.nm, "ex_rd", 32'(ex_rd), 32'(me.rd));
      end
    end
  end
  function automatic exp_t mk(string nm, bit v, bit we, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] rtd, logic [4:0] rd, bit lu, bit mops);
    exp_t e;
    e.nm = nm; e.v = v; e.we = we; e.op = op; e.a = a; e.b = b;
    e.rtd = rtd; e.rd = rd; e.lu = lu; e.mops = mops;
    return e;
  endfunction
  task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm, input bit src, input logic [3:0] op,
                        input logic [4:0] rd, input bit we, input bit mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_src_imm = src; id_alu_op = op; id_rd = rd; id_reg_write = we; id_mem_read = mr;
  endtask
  task automatic set_fwd(input bit ew, input logic [4:0] erd, input logic [31:0] ed,
                         input bit mw, input logic [4:0] mrd, input logic [31:0] md);
    exm_reg_write = ew; exm_rd = erd; exm_data = ed;
    mwb_reg_write = mw; mwb_rd = mrd; mwb_data = md;
  endtask
  task automatic vec(input bit rn, input bit st, input bit fl, input exp_t e);
    rst_n = rn; stall = st; flush = fl;
    q.push_back(e);
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1, 1, 2, 5, 3, 0, 0, 2, 3, 1, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vec(0, 0, 0, mk("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    vec(0, 0, 0, mk("reset2", 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    vec(1, 0, 0, mk("load_reg", 1, 1, 2, 5, 3, 3, 3, 0, 1));
    @(negedge clk);
    set_id(1, 1, 2, 5, 3, 32'hFFFF_FFFC, 1, 6, 7, 1, 0);
    vec(1, 0, 0, mk("load_imm", 1, 1, 6, 5, 32'hFFFF_FFFC, 3, 7, 0, 1));
    @(negedge clk);
    set_id(1, 8, 2, 32'h11, 3, 0, 0, 0, 6, 1, 0);
    set_fwd(1, 8, 32'hAA, 1, 8, 32'hBB);
    vec(1, 0, 0, mk("fwd_exm_prio", 1, 1, 0, FWD ? 32'hAA : 32'h11, 3, 3, 6, 0, 1));
    @(negedge clk);
    set_fwd(0, 8, 32'hAA, 1, 8, 32'hBB);
    vec(1, 1, 0, mk("fwd_mwb", 1, 1, 0, FWD ? 32'hBB : 32'h11, 3, 3, 6, 0, 1));
    @(negedge clk);
    set_id(1, 0, 2, 32'h22, 3, 0, 0, 0, 6, 1, 0);
    set_fwd(1, 0, 32'hCC, 0, 8, 32'hBB);
    vec(1, 0, 0, mk("fwd_r0", 1, 1, 0, 32'h22, 3, 3, 6, 0, 1));
    @(negedge clk);
    set_id(1, 1, 9, 32'h10, 32'h33, 0, 0, 1, 6, 1, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    vec(1, 0, 0, mk("stall_pre", 1, 1, 1, 32'h10, 32'h33, 32'h33, 6, 0, 1));
    @(negedge clk);
    set_id(1, 3, 3, 32'hDEAD, 32'hBEEF, 0, 0, 12, 2, 0, 0);
    set_fwd(0, 0, 0, 1, 9, 32'h77);
    vec(1, 1, 0, mk("stall_fwd", 1, 1, 1, 32'h10, FWD ? 32'h77 : 32'h33, FWD ? 32'h77 : 32'h33, 6, 0, 1));
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 9, 32'h0);
    vec(1, 1, 0, mk("stall_hold", 1, 1, 1, 32'h10, FWD ? 32'h77 : 32'h33, FWD ? 32'h77 : 32'h33, 6, 0, 1));
    @(negedge clk);
    set_id(1, 1, 9, 32'h10, 32'h33, 32'h40, 1, 2, 6, 1, 0);
    set_fwd(1, 9, 32'h55, 0, 0, 0);
    vec(1, 0, 0, mk("store_fwd", 1, 1, 2, 32'h10, 32'h40, FWD ? 32'h55 : 32'h33, 6, 0, 1));
    @(negedge clk);
    set_id(1, 4, 2, 1, 2, 0, 0, 2, 4, 1, 1);
    set_fwd(0, 0, 0, 0, 0, 0);
    vec(1, 0, 0, mk("lu_rs", 1, 1, 2, 1, 2, 2, 4, 1, 1));
    @(negedge clk);
    set_id(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(1, 1, 0, mk("lu_rt", 1, 1, 2, 1, 2, 2, 4, 1, 1));
    @(negedge clk);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(1, 1, 0, mk("lu_nomatch", 1, 1, 2, 1, 2, 2, 4, 0, 1));
    @(negedge clk);
    set_id(0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    vec(1, 1, 0, mk("lu_id_inval", 1, 1, 2, 1, 2, 2, 4, 0, 1));
    @(negedge clk);
    set_id(1, 0, 0, 32'h66, 32'h67, 0, 0, 2, 0, 1, 1);
    vec(1, 0, 0, mk("lu_rd0", 1, 1, 2, 32'h66, 32'h67, 32'h67, 0, 0, 1));
    @(negedge clk);
    set_id(1, 0, 0, 32'h99, 32'h44, 0, 0, 7, 5, 1, 0);
    vec(1, 1, 1, mk("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    vec(1, 0, 0, mk("after_flush", 1, 1, 7, 32'h99, 32'h44, 32'h44, 5, 0, 1));
    @(negedge clk);
    vec(1, 0, 1, mk("flush_only", 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    set_id(0, 1, 2, 32'h1, 32'h2, 0, 0, 12, 5, 1, 1);
    vec(1, 0, 0, mk("invalid_load", 0, 0, 12, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
